// File: rtl/iter_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// iter_muldiv_unit_if
// Request/response bundle for the iterative multiply/divide unit.
//
// Handshake rule (both sides): a transfer happens on the rising clock edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge. valid never waits on ready.
//
// Signals
//   flush     : abort any in-flight or pending operation (synchronous)
//   in_valid  : request valid                 (master -> unit)
//   in_ready  : unit can accept a request     (unit -> master)
//   op        : 000 MUL, 001 MUH, 010 MULU, 011 MUHU,
//               100 DIV, 101 MOD, 110 DIVU, 111 MODU
//   src_a     : multiplicand / dividend
//   src_b     : multiplier / divisor
//   out_valid : result valid                  (unit -> master)
//   out_ready : consumer accepts the result   (master -> unit)
//   result    : selected result
//   div_zero  : divide op had src_b == 0 (qualified by out_valid)
// ---------------------------------------------------------------------------
interface iter_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             div_zero;

   modport master (
      output flush, in_valid, op, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, div_zero
   );

   modport slave (
      input  flush, in_valid, op, src_a, src_b, out_ready,
      output in_ready, out_valid, result, div_zero
   );
endinterface

// File: rtl/iter_muldiv_unit.sv
// ---------------------------------------------------------------------------
// iter_muldiv_unit
// Multi-cycle multiply/divide unit: radix-2 shift-add multiply and restoring
// division on operand magnitudes, with sign fix-up on the final iteration.
// Divide-by-zero and signed MIN / -1 complete one cycle after accept.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : iter_muldiv_unit_if.slave (handshakes, operands, result)
//   state_dbg : current FSM state (0 IDLE, 1 CALC, 2 DONE)
// ---------------------------------------------------------------------------
module iter_muldiv_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   iter_muldiv_unit_if.slave     bus,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         op_q;
   logic               neg_q;      // final value needs negation
   logic [WIDTH-1:0]   mag_m;      // multiplicand (mul) or divisor (div) magnitude
   logic [2*WIDTH-1:0] acc;        // mul: product/multiplier; div: {remainder, quotient}
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   result_q;
   logic               div_zero_q;

   // ---------------- accept-cycle decode ----------------
   logic             accept, is_div, is_sgn, sign_a, sign_b;
   logic             b_zero, ovf, fast, neg_in, last;
   logic [WIDTH-1:0] mag_a, mag_b, fast_res;

   assign accept = (state == S_IDLE) && bus.in_valid && !bus.flush;
   assign is_div = bus.op[2];
   assign is_sgn = !bus.op[1];
   assign sign_a = is_sgn && bus.src_a[WIDTH-1];
   assign sign_b = is_sgn && bus.src_b[WIDTH-1];
   assign mag_a  = sign_a ? -bus.src_a : bus.src_a;
   assign mag_b  = sign_b ? -bus.src_b : bus.src_b;
   assign b_zero = (bus.src_b == '0);
   assign ovf    = is_div && is_sgn && (bus.src_a == MIN_VAL) && (bus.src_b == '1);
   assign fast   = is_div && (b_zero || ovf);
   // Remainder follows the dividend's sign; everything else follows sign_a ^ sign_b.
   assign neg_in = (is_div && bus.op[0]) ? sign_a : (sign_a ^ sign_b);
   assign fast_res = b_zero ? (bus.op[0] ? bus.src_a : '1)
                            : (bus.op[0] ? '0 : MIN_VAL);
   assign last   = (cnt == CNT_W'(1));

   // ---------------- one iteration ----------------
   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [WIDTH-1:0]   rem_nxt, quo_nxt;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_m} : '0);
      mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
      // Bring next dividend bit into the partial remainder; a borrow in
      // bit WIDTH means the divisor did not fit, so keep the old value.
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_trial = div_shift - {1'b0, mag_m};
      rem_nxt   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      quo_nxt   = {acc[WIDTH-2:0], !div_trial[WIDTH]};
      acc_nxt   = op_q[2] ? {rem_nxt, quo_nxt} : mul_nxt;
   end

   // ---------------- final sign fix-up and select ----------------
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   div_sel, fin_res;

   always_comb begin
      prod_s  = neg_q ? -acc_nxt : acc_nxt;
      div_sel = op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
      if (op_q[2])
         fin_res = neg_q ? -div_sel : div_sel;
      else
         fin_res = op_q[0] ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)        state_nxt = fast ? S_DONE : S_CALC;
         S_CALC:  if (last)          state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
         default:                    state_nxt = S_IDLE;
      endcase
      if (bus.flush) state_nxt = S_IDLE;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.in_ready  = (state == S_IDLE);
      bus.out_valid = (state == S_DONE);
   end

   assign bus.result   = result_q;
   assign bus.div_zero = div_zero_q;
   assign state_dbg    = state;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         op_q       <= '0;
         neg_q      <= 1'b0;
         mag_m      <= '0;
         acc        <= '0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
      end else if (bus.flush) begin
         cnt <= '0;
      end else if (accept) begin
         op_q       <= bus.op;
         neg_q      <= neg_in;
         mag_m      <= is_div ? mag_b : mag_a;
         acc        <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
         cnt        <= fast ? '0 : CNT_W'(WIDTH);
         div_zero_q <= is_div && b_zero;
         if (fast) result_q <= fast_res;
      end else if (state == S_CALC) begin
         acc <= acc_nxt;
         cnt <= cnt - CNT_W'(1);
         if (last) result_q <= fin_res;
      end
   end

endmodule
